// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: decodes the upper address into one-hot chip selects and
// terminates each bus cycle with DTACK (wait-state counted or external) or BERR.
module m68k_bus_ctrl #(
    parameter int                      NREGIONS     = 4,
    parameter int                      ADDR_LSB     = 13,
    parameter logic [NREGIONS*24-1:0]  REGION_BASE  = {24'h020000, 24'h010000, 24'h004000, 24'h000000},
    parameter logic [NREGIONS*24-1:0]  REGION_LIMIT = {24'h040000, 24'h020000, 24'h010000, 24'h004000},
    parameter logic [NREGIONS*4-1:0]   REGION_WS    = {4'd2, 4'd0, 4'd3, 4'd0},
    parameter logic [NREGIONS-1:0]     REGION_EXT   = '0,
    parameter int                      BERR_TIMEOUT = 64
) (
    input  logic                  clk16,
    input  logic                  reset,
    input  logic                  as_n,
    input  logic                  uds_n,
    input  logic                  lds_n,
    input  logic                  rw,
    input  logic [23:ADDR_LSB]    addr,
    input  logic                  boot,
    input  logic                  ext_dtack_n,
    output logic [NREGIONS-1:0]   cs_n,
    output logic                  oe_n,
    output logic                  dtack_n,
    output logic                  berr_n,
    output logic [1:0]            dbg_state
);

    localparam int RW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
    localparam int TW = $clog2(BERR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_BERR = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [RW-1:0]   region_q, region_d;
    logic            ext_q, ext_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            dtack_n_q, dtack_n_d;
    logic            berr_n_q, berr_n_d;

    logic [23:0]     full_addr;
    logic            hit;
    logic [RW-1:0]   hit_idx;
    logic [3:0]      hit_ws;
    logic            hit_ext;

    assign full_addr = {addr, {ADDR_LSB{1'b0}}};

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_ws  = 4'd0;
        hit_ext = 1'b0;
        for (int i = NREGIONS - 1; i >= 0; i--) begin
            if (full_addr >= REGION_BASE[i*24 +: 24] && full_addr < REGION_LIMIT[i*24 +: 24]) begin
                hit     = 1'b1;
                hit_idx = RW'(i);
                hit_ws  = REGION_WS[i*4 +: 4];
                hit_ext = REGION_EXT[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q | as_n;
        region_d = region_q;
        ext_d    = ext_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                // Only accept after as_n has been seen high, so a cycle straddling reset is dropped.
                if (armed_q && !as_n) begin
                    region_d = hit_idx;
                    ext_d    = hit_ext;
                    tcnt_d   = '0;
                    wcnt_d   = 4'd0;
                    if (!hit)
                        state_d = ST_BERR;
                    else if (hit_ext)
                        state_d = ST_WAIT;
                    else if (hit_ws == 4'd0)
                        state_d = ST_ACK;
                    else begin
                        state_d = ST_WAIT;
                        wcnt_d  = hit_ws - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (as_n)
                    state_d = ST_IDLE;
                else if (ext_q ? !ext_dtack_n : (wcnt_q == 4'd0))
                    state_d = ST_ACK;
                else begin
                    if (!ext_q)
                        wcnt_d = wcnt_q - 4'd1;
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_d == TW'(BERR_TIMEOUT))
                        state_d = ST_BERR;
                end
            end
            ST_ACK, ST_BERR: begin
                if (as_n)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        dtack_n_d = (state_d != ST_ACK);
        berr_n_d  = (state_d != ST_BERR);
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            region_q  <= '0;
            ext_q     <= 1'b0;
            wcnt_q    <= 4'd0;
            tcnt_q    <= '0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            region_q  <= region_d;
            ext_q     <= ext_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
        end
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NREGIONS; i++) begin
            if ((state_q == ST_WAIT || state_q == ST_ACK) && region_q == RW'(i)
                && !as_n && !(uds_n & lds_n))
                cs_n[i] = 1'b0;
        end
    end

    assign oe_n      = boot ? 1'b1 : ~(rw & ~as_n);
    assign dtack_n   = dtack_n_q;
    assign berr_n    = berr_n_q;
    assign dbg_state = state_q;

endmodule

// File: doc/m68k_bus_ctrl.md
# m68k_bus_ctrl

Parametrised 68000 bus controller for the CPLD: decodes the upper address bits into NREGIONS one-hot chip selects and generates DTACK per region with programmable wait states. It also supports handshaking with slow external devices and raises a bus-error on unmapped accesses or timeout. It sits between the CPU (clk16 domain) and memory and peripheral chip-select pins. It generalises the fixed EEPROM/RAM/other decoder to N regions with a real cycle-termination FSM.

## Interface
Parameters:
- NREGIONS, 4, number of decoded regions (1..8)
- ADDR_LSB, 13, lowest address bit brought into the CPLD
- REGION_BASE, {24'h010000,24'h004000,24'h000000,…}, packed NREGIONS×24, inclusive base byte address of region i (bits [24i+23:24i])
- REGION_LIMIT, packed NREGIONS×24, exclusive upper byte address of region i
- REGION_WS, packed NREGIONS×4, wait states for region i (0..15)
- REGION_EXT, NREGIONS'b0, bit i=1: region i terminates on ext_dtack_n instead of REGION_WS
- BERR_TIMEOUT, 64, max clk16 cycles spent in WAIT before bus error (must exceed 15)

Ports:
- clk16  in  1  CPU clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- as_n  in  1  address strobe
- uds_n, lds_n  in  1 each  data strobes
- rw  in  1  1=read
- addr  in  24-ADDR_LSB  addr[23:ADDR_LSB]
- boot  in  1  bootloader mode
- ext_dtack_n  in  1  termination from external slow devices
- cs_n  out  NREGIONS  active-low one-hot chip selects
- oe_n  out  1  shared output enable
- dtack_n  out  1  data transfer acknowledge to CPU
- berr_n  out  1  bus error to CPU

## Operation
- Decode: a = {addr, ADDR_LSB'b0}. Region i hits if BASE_i <= a < LIMIT_i. Lowest index wins on overlap. No hit = unmapped.
- FSM states: IDLE, WAIT, ACK, BERR; reset state IDLE with armed=0.
- armed: cleared by reset, set when as_n sampled high. IDLE ignores as_n low while armed=0. This means a cycle in progress across reset is never acknowledged.
- IDLE, armed, as_n=0: latch region index and the hit/unmapped flag.
  - unmapped → BERR
  - EXT region → WAIT
  - WS=0 → ACK
  - else WAIT with wcnt=WS-1
- WAIT, counter region: wcnt==0 → ACK, else wcnt-1.
- WAIT, EXT region: ext_dtack_n sampled 0 → ACK.
- WAIT, any region: tcnt counts cycles in WAIT. Reaching BERR_TIMEOUT → BERR. tcnt is cleared on WAIT entry.
- as_n sampled high in WAIT (CPU aborted) → IDLE, no dtack/berr.
- ACK: dtack_n=0 until as_n sampled high → IDLE.
- BERR: berr_n=0 until as_n sampled high → IDLE.
- cs_n[i] = 0 only when all of these hold:
  - state ∈ {WAIT, ACK}
  - latched region = i
  - as_n=0
  - (uds_n & lds_n)=0
  
  Combinational from registered state/region and live strobes. It is never asserted in BERR or IDLE.
- oe_n = 1 if boot. Otherwise oe_n = ~(rw & ~as_n).
- Never dtack_n and berr_n low together.

## Timing
- Reset values: state IDLE, armed=0, wcnt=0, tcnt=0, cs_n=all 1, dtack_n=1, berr_n=1. oe_n follows its combinational equation.
- dtack_n and berr_n are registered (state-decoded flops).
- E0 = edge at which IDLE accepts as_n low. dtack_n falls after edge E0+WS (WS=0: right after E0).
- EXT: dtack_n falls after the edge that samples ext_dtack_n=0.
- Timeout: berr_n falls after edge E0+BERR_TIMEOUT.
- Unmapped: berr_n falls after E0.
- dtack_n/berr_n rise after the first edge sampling as_n=1. Next cycle acceptance is possible on the following edge.
- Reset mid-cycle: outputs go inactive immediately (async). No new cycle starts until as_n has been seen high.
- as_n, strobes, addr and ext_dtack_n are treated as synchronous to clk16. No synchronisers.

## Test plan
- Default params, read at 0x000100, WS_0=0: dtack_n low after E0, cs_n=4'b1110 while uds_n low, oe_n=0; as_n high → dtack_n=1 one edge later.
- Region 1 (0x004000..0x00FFFF), WS_1=3: dtack_n low exactly after E0+3; cs_n[1]=0 from E0; write (rw=0) keeps oe_n=1.
- Region 2 EXT, hold ext_dtack_n=1 for 10 cycles then 0 → dtack_n low after that edge. Repeat with ext_dtack_n stuck 1 → berr_n low after E0+64, cs_n all 1, dtack_n stays 1.
- Access above every LIMIT → berr_n low after E0, no cs_n asserted; boot=1 read anywhere → oe_n=1.
- Assert reset during WAIT with as_n held low → outputs inactive immediately; after reset release no dtack until as_n toggles high then low; the next cycle then completes normally.
- Overlapping REGION_BASE/LIMIT for regions 0 and 1 → only cs_n[0] asserted, WS_0 used.
